// File: rtl/oipuf_multi_eval.sv
// Majority-vote controller: one challenge in flight; the response is valid NEVAL*(RELAX_CYC+SETTLE_CYC)+1 edges after accept and held until rsp_ready.
// Define OIPUF_STAB_MASK_EN to exclude unstable lines from rsp_xor.
module oipuf_multi_eval #(
  parameter int TW         = 4,
  parameter int ST         = 64,
  parameter int NEVAL      = 5,
  parameter int RELAX_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [ST-1:0] req_chal,
  output logic          trig,
  output logic [ST-1:0] puf_chal,
  input  logic [TW-1:0] puf_resp,
  input  logic [TW-1:0] puf_stable,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [TW-1:0] rsp_bits,
  output logic          rsp_xor,
  output logic [TW-1:0] rsp_unstable
);

  localparam int OW   = $clog2(NEVAL + 1);
  localparam int CMAX = (RELAX_CYC > SETTLE_CYC) ? RELAX_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [OW-1:0] NEVAL_W = OW'(NEVAL);

  typedef enum logic [2:0] {IDLE, RELAX, FIRE, VOTE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [OW-1:0] eval_cnt;
  logic [OW-1:0] ones [TW];
  logic [TW-1:0] bad;
  logic          relax_last, fire_last, eval_last;
  logic [TW-1:0] vote_bits, vote_unst;
  logic          vote_xor;

  assign relax_last = (cnt == CW'(RELAX_CYC - 1));
  assign fire_last  = (cnt == CW'(SETTLE_CYC - 1));
  assign eval_last  = (eval_cnt == OW'(NEVAL - 1));

  assign req_ready = (state == IDLE);
  assign trig      = (state == FIRE);
  assign rsp_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = RELAX;
      RELAX: if (relax_last) state_nxt = FIRE;
      FIRE:  if (fire_last) state_nxt = eval_last ? VOTE : RELAX;
      VOTE:  state_nxt = DONE;
      DONE:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A line is unstable if it ever flagged itself or its samples disagreed.
  always_comb begin
    vote_bits = '0;
    vote_unst = '0;
    for (int i = 0; i < TW; i++) begin
      vote_bits[i] = (2 * int'(ones[i])) > NEVAL;
      vote_unst[i] = bad[i] || ((ones[i] != '0) && (ones[i] != NEVAL_W));
    end
  end

`ifdef OIPUF_STAB_MASK_EN
  assign vote_xor = ^(vote_bits & ~vote_unst);
`else
  assign vote_xor = ^vote_bits;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      puf_chal     <= '0;
      cnt          <= '0;
      eval_cnt     <= '0;
      bad          <= '0;
      rsp_bits     <= '0;
      rsp_unstable <= '0;
      rsp_xor      <= 1'b0;
      for (int i = 0; i < TW; i++) ones[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            puf_chal <= req_chal;
            cnt      <= '0;
            eval_cnt <= '0;
            bad      <= '0;
            for (int i = 0; i < TW; i++) ones[i] <= '0;
          end
        end
        RELAX: cnt <= relax_last ? '0 : cnt + CW'(1);
        FIRE: begin
          cnt <= fire_last ? '0 : cnt + CW'(1);
          if (fire_last) begin
            eval_cnt <= eval_cnt + OW'(1);
            for (int i = 0; i < TW; i++) begin
              if (puf_resp[i] && (ones[i] != NEVAL_W)) ones[i] <= ones[i] + OW'(1);
              if (!puf_stable[i]) bad[i] <= 1'b1;
            end
          end
        end
        VOTE: begin
          rsp_bits     <= vote_bits;
          rsp_unstable <= vote_unst;
          rsp_xor      <= vote_xor;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oipuf_multi_eval.sv
// Scoreboard bench: instance a is the default 5-shot build, instance b a single-shot build (NEVAL=1, R=1, S=1).
module tb_oipuf_multi_eval;

  typedef struct packed {
    logic [3:0] bits;
    logic [3:0] unst;
    logic       x;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_trig, a_rsp_valid, a_rsp_ready, a_rsp_xor;
  logic [63:0] a_req_chal, a_puf_chal;
  logic [3:0]  a_puf_resp, a_puf_stable, a_rsp_bits, a_rsp_unstable;

  logic        b_req_valid, b_req_ready, b_trig, b_rsp_valid, b_rsp_ready, b_rsp_xor;
  logic [7:0]  b_req_chal, b_puf_chal;
  logic [3:0]  b_puf_resp, b_puf_stable, b_rsp_bits, b_rsp_unstable;

  oipuf_multi_eval u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_chal(a_req_chal),
    .trig(a_trig), .puf_chal(a_puf_chal), .puf_resp(a_puf_resp), .puf_stable(a_puf_stable),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_bits(a_rsp_bits),
    .rsp_xor(a_rsp_xor), .rsp_unstable(a_rsp_unstable)
  );

  oipuf_multi_eval #(.TW(4), .ST(8), .NEVAL(1), .RELAX_CYC(1), .SETTLE_CYC(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_chal(b_req_chal),
    .trig(b_trig), .puf_chal(b_puf_chal), .puf_resp(b_puf_resp), .puf_stable(b_puf_stable),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_bits(b_rsp_bits),
    .rsp_xor(b_rsp_xor), .rsp_unstable(b_rsp_unstable)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [3:0] s_resp [5];
  logic [3:0] s_stab [5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected vote for the first n entries of the sample tables.
  function automatic exp_t model(input int n);
    exp_t e;
    int   cnt1;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      cnt1 = 0;
      for (int k = 0; k < n; k++) if (s_resp[k][i]) cnt1++;
      e.bits[i] = (2 * cnt1 > n);
      e.unst[i] = (cnt1 != 0) && (cnt1 != n);
      for (int k = 0; k < n; k++) if (!s_stab[k][i]) e.unst[i] = 1'b1;
    end
`ifdef OIPUF_STAB_MASK_EN
    e.x = ^(e.bits & ~e.unst);
`else
    e.x = ^e.bits;
`endif
    return e;
  endfunction

  task automatic run_a(input string tag, input logic [63:0] chal, input int hold);
    exp_t e;
    int   terr, verr, cerr, serr;
    terr = 0; verr = 0; cerr = 0; serr = 0;
    chk({tag, "_req_ready"}, a_req_ready, 1);
    a_req_chal = chal; a_req_valid = 1'b1;
    a_puf_resp = s_resp[0]; a_puf_stable = s_stab[0];
    tick();
    a_req_valid = 1'b0;
    sb_a.push_back(model(5));
    // Each evaluation spans 5 edges: 2 relax then 3 fire; vote after edge 25, done after 26.
    for (int t = 1; t <= 26; t++) begin
      tick();
      if ((t % 5 == 0) && (t < 25)) begin
        a_puf_resp = s_resp[t/5]; a_puf_stable = s_stab[t/5];
      end
      if (a_trig !== ((t < 25) && (t % 5 >= 2))) terr++;
      if (a_rsp_valid !== (t == 26)) verr++;
      if (a_puf_chal !== chal) cerr++;
    end
    a_puf_resp = ~a_puf_resp;
    a_puf_stable = 4'h0;
    chk({tag, "_trig_seq"}, terr, 0);
    chk({tag, "_valid_latency"}, verr, 0);
    chk({tag, "_chal_hold"}, cerr, 0);
    if (sb_a.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_a.pop_front();
    chk({tag, "_bits"}, a_rsp_bits, e.bits);
    chk({tag, "_unstable"}, a_rsp_unstable, e.unst);
    chk({tag, "_xor"}, a_rsp_xor, e.x);
    for (int h = 0; h < hold; h++) begin
      a_req_valid = h[0];
      tick();
      if (a_rsp_bits !== e.bits || a_rsp_unstable !== e.unst || a_rsp_xor !== e.x ||
          a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0) serr++;
    end
    a_req_valid = 1'b0;
    chk({tag, "_hold_stable"}, serr, 0);
    chk({tag, "_ready_low_in_done"}, a_req_ready, 0);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk({tag, "_ready_after_hs"}, a_req_ready, 1);
    chk({tag, "_valid_after_hs"}, a_rsp_valid, 0);
  endtask

  task automatic run_a_reset(input logic [63:0] chal);
    exp_t e;
    int   verr;
    verr = 0;
    a_req_chal = chal; a_req_valid = 1'b1;
    a_puf_resp = s_resp[0]; a_puf_stable = s_stab[0];
    tick();
    a_req_valid = 1'b0;
    sb_a.push_back(model(5));
    for (int t = 1; t <= 7; t++) tick();
    chk("rst_in_second_fire", a_trig, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_trig", a_trig, 0);
    chk("rst_valid", a_rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_ready", a_req_ready, 1);
    chk("rst_release_trig", a_trig, 0);
    chk("rst_release_chal", a_puf_chal, 0);
    e = sb_a.pop_back();
    for (int t = 0; t < 40; t++) begin
      tick();
      if (a_rsp_valid !== 1'b0 || a_trig !== 1'b0) verr++;
    end
    chk("rst_no_response", verr, 0);
  endtask

  task automatic run_b(input string tag, input logic [7:0] chal);
    exp_t e;
    int   verr;
    verr = 0;
    chk({tag, "_req_ready"}, b_req_ready, 1);
    b_req_chal = chal; b_req_valid = 1'b1;
    b_puf_resp = s_resp[0]; b_puf_stable = s_stab[0];
    tick();
    b_req_valid = 1'b0;
    sb_b.push_back(model(1));
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (b_rsp_valid !== (t == 3)) verr++;
      if (b_trig !== (t == 1)) verr++;
    end
    chk({tag, "_timing"}, verr, 0);
    chk({tag, "_chal"}, b_puf_chal, chal);
    if (sb_b.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_b.pop_front();
    chk({tag, "_bits"}, b_rsp_bits, e.bits);
    chk({tag, "_unstable"}, b_rsp_unstable, e.unst);
    chk({tag, "_xor"}, b_rsp_xor, e.x);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    chk({tag, "_ready_after_hs"}, b_req_ready, 1);
  endtask

  initial begin
    logic [4:0] seq;
    a_req_valid = 0; a_rsp_ready = 0; a_req_chal = '0; a_puf_resp = '0; a_puf_stable = '0;
    b_req_valid = 0; b_rsp_ready = 0; b_req_chal = '0; b_puf_resp = '0; b_puf_stable = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_req_ready", a_req_ready, 1);
    chk("reset_trig", a_trig, 0);
    chk("reset_puf_chal", a_puf_chal, 0);
    chk("reset_rsp_valid", a_rsp_valid, 0);
    chk("reset_rsp_bits", a_rsp_bits, 0);
    chk("reset_rsp_unstable", a_rsp_unstable, 0);
    chk("reset_rsp_xor", a_rsp_xor, 0);
    chk("reset_b_rsp_valid", b_rsp_valid, 0);

    // Constant 1010 on all samples, all stable.
    for (int k = 0; k < 5; k++) begin s_resp[k] = 4'b1010; s_stab[k] = 4'hF; end
    run_a("const1010", 64'hDEAD_BEEF_0123_4567, 0);

    // Line 0 sees 1,1,0,1,0; other lines 0.
    seq = 5'b01011;
    for (int k = 0; k < 5; k++) begin s_resp[k] = {3'b000, seq[k]}; s_stab[k] = 4'hF; end
    run_a("line0_split", 64'h0000_0000_0000_00A5, 0);

    // Line 2 reports unstable on the third sample only.
    for (int k = 0; k < 5; k++) begin s_resp[k] = 4'b0110; s_stab[k] = 4'hF; end
    s_stab[2] = 4'b1011;
    run_a("line2_glitch", 64'h1234_5678_9ABC_DEF0, 0);

    // Random samples with a long response stall.
    for (int k = 0; k < 5; k++) begin
      s_resp[k] = 4'($urandom_range(0, 15)); s_stab[k] = 4'hF;
    end
    run_a("stall10", 64'hCAFE_F00D_5555_AAAA, 10);

    // Reset during the second fire, then a normal transaction.
    run_a_reset(64'hFFFF_0000_FFFF_0000);
    for (int k = 0; k < 5; k++) begin
      s_resp[k] = 4'($urandom_range(0, 15)); s_stab[k] = 4'($urandom_range(0, 15)) | 4'b1000;
    end
    run_a("post_reset", 64'h0F0F_0F0F_0F0F_0F0F, 2);

    // Single-shot instance: bits pass through, unstable follows puf_stable only.
    s_resp[0] = 4'b0110; s_stab[0] = 4'b1011;
    run_b("single_a", 8'h5A);
    s_resp[0] = 4'b1001; s_stab[0] = 4'hF;
    run_b("single_b", 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oipuf_multi_eval.md
OIPUF_MULTI_EVAL -- requirements
Module: oipuf_multi_eval

Interface
REQ-001 The block SHALL have parameter TW, default 4: number of PUF lines/arbiters.
REQ-002 The block SHALL have parameter ST, default 64: challenge width.
REQ-003 The block SHALL have parameter NEVAL, default 5: evaluations per challenge, odd, 1..255.
REQ-004 The block SHALL have parameter RELAX_CYC, default 2: trigger-low cycles per evaluation, at least 1.
REQ-005 The block SHALL have parameter SETTLE_CYC, default 3: trigger-high cycles per evaluation, at least 1.
REQ-006 The block SHALL have one clock and a synchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-007 The block SHALL have req_valid input 1: challenge request.
REQ-008 The block SHALL have req_ready output 1: request accepted when both req_valid and req_ready are high.
REQ-009 The block SHALL have req_chal input ST: challenge.
REQ-010 The block SHALL have trig output 1: launch/arbiter-reset drive to the PUF core.
REQ-011 The block SHALL have puf_chal output ST: registered challenge to the PUF core.
REQ-012 The block SHALL have puf_resp input TW: per-line arbiter outputs.
REQ-013 The block SHALL have puf_stable input TW: per-line stable flags, 1 = resolved cleanly.
REQ-014 The block SHALL have rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-015 The block SHALL have rsp_bits output TW: per-line majority vote.
REQ-016 The block SHALL have rsp_xor output 1: XOR-combined final bit.
REQ-017 The block SHALL have rsp_unstable output TW: per-line disagreement flag.

Function
REQ-018 The FSM SHALL have states IDLE, RELAX, FIRE, VOTE and DONE.
REQ-019 req_ready SHALL be high only in IDLE; on acceptance the block SHALL register req_chal into puf_chal, clear all counters and go to RELAX.
REQ-020 puf_chal SHALL hold constant from acceptance until the return to IDLE.
REQ-021 trig SHALL be 0 in IDLE, RELAX, VOTE and DONE, and 1 in FIRE.
REQ-022 RELAX SHALL last exactly RELAX_CYC cycles and then go to FIRE.
REQ-023 FIRE SHALL last exactly SETTLE_CYC cycles; on its final edge the block SHALL sample puf_resp and puf_stable and increment the evaluation counter.
REQ-024 After a sample, the FSM SHALL go to RELAX if fewer than NEVAL samples have been taken, else to VOTE.
REQ-025 Per line i, the block SHALL keep a ones counter ones[i], clog2(NEVAL+1) bits wide, that saturates at NEVAL and never wraps.
REQ-026 Per line i, the block SHALL keep a sticky flag bad[i], set by any sample with puf_stable[i] = 0.
REQ-027 In VOTE (one cycle), the block SHALL register rsp_bits[i] = (2*ones[i] > NEVAL) and rsp_unstable[i] = bad[i] OR (ones[i] neither 0 nor NEVAL), then go to DONE.
REQ-028 rsp_valid SHALL be high in DONE only, first high after edge NEVAL*(RELAX_CYC+SETTLE_CYC)+1 counted from the accepting edge.
REQ-029 rsp_bits, rsp_xor and rsp_unstable SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-030 On rsp_valid and rsp_ready both high, the block SHALL go to IDLE; req_ready SHALL rise the following cycle, so no same-cycle accept is possible.
REQ-031 req_valid SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside DONE.
REQ-032 With NEVAL = 1, the block SHALL pass the single sample through, and rsp_unstable SHALL reflect puf_stable only.

Reset
REQ-033 rst_n sampled low SHALL force IDLE from any state, including mid-FIRE, on the same edge.
REQ-034 During and after reset: req_ready = 1 after release, trig = 0, puf_chal = 0, rsp_valid = 0, rsp_bits = 0, rsp_xor = 0, rsp_unstable = 0, counters and bad flags = 0.
REQ-035 An evaluation interrupted by reset SHALL never produce a response.

Configuration
REQ-036 With OIPUF_STAB_MASK_EN defined, rsp_xor SHALL be the XOR of rsp_bits[i] over lines with rsp_unstable[i] = 0; if all lines are unstable, rsp_xor = 0.
REQ-037 With OIPUF_STAB_MASK_EN undefined, rsp_xor SHALL be the XOR of all TW rsp_bits; rsp_unstable is still reported.

Verification
REQ-038 The bench SHALL cover: TW=4, NEVAL=5, R=2, S=3; puf_resp=4'b1010 constant, puf_stable=4'hF -> rsp_valid after edge 26, rsp_bits=1010, rsp_unstable=0000, rsp_xor=0.
REQ-039 The bench SHALL cover: line0 returns 1,1,0,1,0 across the five samples, others 0 -> rsp_bits[0]=1, rsp_unstable=0001, rsp_xor=1 with the macro undefined, rsp_xor=0 with it defined.
REQ-040 The bench SHALL cover: puf_stable[2]=0 on the third sample only -> rsp_unstable[2]=1, rsp_bits[2] still equals the majority.
REQ-041 The bench SHALL cover: rst_n low during the second FIRE -> trig=0 and req_ready=1 after release, no rsp_valid; a new request then completes normally.
REQ-042 The bench SHALL cover: rsp_ready held low 10 cycles in DONE -> outputs stable; req_valid pulses are ignored; req_ready rises 1 cycle after the handshake.
REQ-043 The bench SHALL cover: NEVAL=1, R=1, S=1 -> rsp_valid after edge 3, rsp_bits equals the single sample.
